// File: rtl/inst_fetch.sv
// Instruction fetch stage: assembles 32-bit little-endian instructions from four
// byte reads and presents them, with a valid flag, to the IF/ID register.
// Supports a downstream stall and an immediate PC redirect from later stages.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_valid_in,
    input  logic [7:0]  mem_data_in,
    input  logic        stall_in,
    input  logic        branch_e_in,
    input  logic [31:0] branch_target_in,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid_out
);

    typedef enum logic [0:0] {StFetch, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] buf_q, buf_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic        inst_valid_q, inst_valid_d;

    logic        slot_blocked;
    logic        accept;

    // Memory request: held low in reset, while draining, and when the last byte
    // could not be placed because the presented instruction is stalled.
    always_comb begin
        slot_blocked = (byte_cnt_q == 2'd3) && inst_valid_q && stall_in;
        mem_req_out  = rst_in && (state_q == StFetch) && !slot_blocked;
        mem_addr_out = rst_in ? (pc_q + {30'd0, byte_cnt_q}) : 32'd0;
        accept       = mem_req_out && mem_valid_in;
    end

    // Next-state: redirect first, then fetch/load and output consumption.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        byte_cnt_d   = byte_cnt_q;
        buf_d        = buf_q;
        pc_out_d     = pc_out_q;
        inst_out_d   = inst_out_q;
        inst_valid_d = inst_valid_q;

        if (branch_e_in) begin
            pc_d         = {branch_target_in[31:2], 2'b00};
            byte_cnt_d   = 2'd0;
            inst_valid_d = 1'b0;
            if (state_q == StFetch) begin
                // A request still waiting for its byte must be drained first.
                state_d = (mem_req_out && !mem_valid_in) ? StDrain : StFetch;
            end else begin
                // The stale byte arriving this very cycle still ends the drain;
                // otherwise keep waiting for it.
                state_d = mem_valid_in ? StFetch : StDrain;
            end
        end else begin
            if (inst_valid_q && !stall_in) begin
                inst_valid_d = 1'b0;
            end
            unique case (state_q)
                StFetch: begin
                    if (accept) begin
                        if (byte_cnt_q != 2'd3) begin
                            buf_d[8*byte_cnt_q +: 8] = mem_data_in;
                            byte_cnt_d               = byte_cnt_q + 2'd1;
                        end else begin
                            // Load wins over consumption at the same edge.
                            inst_out_d   = {mem_data_in, buf_q};
                            pc_out_d     = pc_q;
                            inst_valid_d = 1'b1;
                            pc_d         = pc_q + 32'd4;
                            byte_cnt_d   = 2'd0;
                        end
                    end
                end
                StDrain: begin
                    if (mem_valid_in) begin
                        state_d = StFetch;
                    end
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            byte_cnt_q   <= 2'd0;
            buf_q        <= 24'd0;
            pc_out_q     <= 32'd0;
            inst_out_q   <= 32'd0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            byte_cnt_q   <= byte_cnt_d;
            buf_q        <= buf_d;
            pc_out_q     <= pc_out_d;
            inst_out_q   <= inst_out_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign pc_out         = pc_out_q;
    assign inst_out       = inst_out_q;
    assign inst_valid_out = inst_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: latency-configurable byte memory model, scoreboard of
// expected request addresses and expected presented instructions.
module tb_inst_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_valid_in = 1'b0;
    logic [7:0]  mem_data_in = 8'd0;
    logic        stall_in;
    logic        branch_e_in;
    logic [31:0] branch_target_in;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid_out;

    int total = 0;
    int bad   = 0;
    int lat   = 1;

    exp_t        exp_inst[$];
    logic [31:0] exp_addr[$];

    always #5 clk = ~clk;

    inst_fetch #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .mem_req_out      (mem_req_out),
        .mem_addr_out     (mem_addr_out),
        .mem_valid_in     (mem_valid_in),
        .mem_data_in      (mem_data_in),
        .stall_in         (stall_in),
        .branch_e_in      (branch_e_in),
        .branch_target_in (branch_target_in),
        .pc_out           (pc_out),
        .inst_out         (inst_out),
        .inst_valid_out   (inst_valid_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd(input logic [31:0] a);
        case (a)
            32'h000: rd = 8'h93;  32'h001: rd = 8'h00;
            32'h002: rd = 8'hA0;  32'h003: rd = 8'h00;
            32'h008: rd = 8'h13;  32'h009: rd = 8'h01;
            32'h00A: rd = 8'h10;  32'h00B: rd = 8'h00;
            32'h100: rd = 8'hB3;  32'h101: rd = 8'h81;
            32'h102: rd = 8'h20;  32'h103: rd = 8'h00;
            32'h104: rd = 8'h37;  32'h105: rd = 8'h12;
            32'h200: rd = 8'h6F;
            default: rd = 8'h00;
        endcase
    endfunction

    // Memory model: one request in flight, answered lat cycles after capture.
    logic        busy = 1'b0;
    logic [31:0] maddr = 32'd0;
    int          cnt = 0;
    always @(negedge clk) begin
        if (rst_in !== 1'b1) begin
            busy         = 1'b0;
            mem_valid_in = 1'b0;
        end else begin
            if (mem_valid_in) begin
                mem_valid_in = 1'b0;
                busy         = 1'b0;
            end
            if (!busy && mem_req_out) begin
                busy  = 1'b1;
                maddr = mem_addr_out;
                cnt   = lat;
                if (exp_addr.size() > 0) chk("req_addr", maddr, exp_addr.pop_front());
            end
            if (busy) begin
                if (cnt == 0) begin
                    mem_valid_in = 1'b1;
                    mem_data_in  = rd(maddr);
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Output monitor: compare each instruction in the cycle it is consumed.
    always @(negedge clk) begin
        exp_t e;
        if (rst_in === 1'b1 && inst_valid_out && !stall_in && !branch_e_in &&
            exp_inst.size() > 0) begin
            e = exp_inst.pop_front();
            chk("out_pc", pc_out, e.pc);
            chk("out_inst", inst_out, e.inst);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_inst_drain(input string tag);
        int n = 0;
        while (exp_inst.size() > 0 && n < 100) begin
            tick;
            n++;
        end
        chk(tag, 32'(exp_inst.size()), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] p;
        rst_in           = 1'b0;
        stall_in         = 1'b1;
        branch_e_in      = 1'b0;
        branch_target_in = 32'd0;
        tick;
        tick;
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_inst", inst_out, 32'd0);
        chk("rst_valid", 32'(inst_valid_out), 32'd0);
        chk("rst_req", 32'(mem_req_out), 32'd0);
        chk("rst_addr", mem_addr_out, 32'd0);

        // Basic fetch, then stall with the next instruction blocked at byte 3.
        for (int i = 0; i < 12; i++) exp_addr.push_back(32'(i));
        exp_inst.push_back('{pc: 32'h0, inst: 32'h00A00093});
        rst_in = 1'b1;
        n = 0;
        while (!inst_valid_out && n < 40) begin
            tick;
            n++;
        end
        chk("a_valid", 32'(inst_valid_out), 32'd1);
        chk("a_inst", inst_out, 32'h00A00093);
        chk("a_pc", pc_out, 32'd0);
        repeat (14) tick;
        chk("stall_valid", 32'(inst_valid_out), 32'd1);
        chk("stall_pc", pc_out, 32'd0);
        chk("stall_inst", inst_out, 32'h00A00093);
        chk("stall_req", 32'(mem_req_out), 32'd0);
        chk("stall_addr", mem_addr_out, 32'd7);
        chk("stall_addr_left", 32'(exp_addr.size()), 32'd5);
        exp_inst.push_back('{pc: 32'h4, inst: 32'h0});
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h200 + 32'(i));
        exp_inst.push_back('{pc: 32'h200, inst: 32'h0000006F});
        stall_in = 1'b0;
        n = 0;
        do begin
            tick;
            n++;
        end while (!(inst_valid_out && pc_out == 32'd4) && n < 20);
        chk("resume_lat", 32'(n), 32'd2);

        // Redirect in the cycle byte 3 of the instruction at 8 is accepted.
        n = 0;
        while (!(mem_req_out && mem_addr_out == 32'd11) && n < 40) begin
            tick;
            n++;
        end
        chk("b_req11", 32'(mem_req_out && mem_addr_out == 32'd11), 32'd1);
        tick;
        branch_e_in      = 1'b1;
        branch_target_in = 32'h200;
        @(negedge clk);
        #1;
        chk("b_byte3_valid", 32'(mem_valid_in), 32'd1);
        tick;
        branch_e_in = 1'b0;
        chk("b_valid_clr", 32'(inst_valid_out), 32'd0);
        chk("b_req", 32'(mem_req_out), 32'd1);
        chk("b_addr", mem_addr_out, 32'h200);
        wait_inst_drain("b_inst_left");
        chk("b_addr_left", 32'(exp_addr.size()), 32'd0);

        // Redirect with a request outstanding on a 3-cycle memory.
        lat    = 3;
        rst_in = 1'b0;
        tick;
        chk("c_rst_valid", 32'(inst_valid_out), 32'd0);
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h1);
        exp_addr.push_back(32'h2);
        for (int i = 0; i < 5; i++) exp_addr.push_back(32'h100 + 32'(i));
        exp_inst.push_back('{pc: 32'h100, inst: 32'h002081B3});
        rst_in = 1'b1;
        n = 0;
        while (!(mem_req_out && mem_addr_out == 32'd2) && n < 40) begin
            tick;
            n++;
        end
        chk("c_req2", 32'(mem_req_out && mem_addr_out == 32'd2), 32'd1);
        branch_e_in      = 1'b1;
        branch_target_in = 32'h100;
        tick;
        branch_e_in = 1'b0;
        chk("c_valid", 32'(inst_valid_out), 32'd0);
        chk("c_drain_req", 32'(mem_req_out), 32'd0);
        n = 0;
        while (!mem_req_out && n < 20) begin
            tick;
            n++;
        end
        chk("c_drain_len", 32'(n), 32'd3);
        chk("c_tgt_addr", mem_addr_out, 32'h100);
        wait_inst_drain("c_inst_left");

        // Misaligned target rounds down to the word.
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h104 + 32'(i));
        exp_inst.push_back('{pc: 32'h104, inst: 32'h00001237});
        branch_e_in      = 1'b1;
        branch_target_in = 32'h106;
        tick;
        branch_e_in = 1'b0;
        n = 0;
        while (!mem_req_out && n < 20) begin
            tick;
            n++;
        end
        chk("e_addr", mem_addr_out, 32'h104);
        wait_inst_drain("e_inst_left");
        chk("e_addr_left", 32'(exp_addr.size()), 32'd0);

        // Reset mid-instruction while an instruction is presented.
        lat      = 1;
        stall_in = 1'b1;
        n = 0;
        while (!inst_valid_out && n < 40) begin
            tick;
            n++;
        end
        p = pc_out + 32'd5;
        n = 0;
        while (!(mem_req_out && mem_addr_out == p) && n < 40) begin
            tick;
            n++;
        end
        chk("d_mid", 32'(inst_valid_out && mem_req_out && mem_addr_out == p), 32'd1);
        rst_in = 1'b0;
        #1;
        chk("d_req_rst", 32'(mem_req_out), 32'd0);
        chk("d_addr_rst", mem_addr_out, 32'd0);
        tick;
        chk("d_pc", pc_out, 32'd0);
        chk("d_inst", inst_out, 32'd0);
        chk("d_valid", 32'(inst_valid_out), 32'd0);
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'(i));
        exp_inst.push_back('{pc: 32'h0, inst: 32'h00A00093});
        rst_in   = 1'b1;
        stall_in = 1'b0;
        wait_inst_drain("d_inst_left");
        chk("d_addr_left", 32'(exp_addr.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
